// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FPU datapath (divider and multiplier).
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int FP_W   = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 2;   // quotient bits Q[24:0] and remainder width

  localparam logic [FP_W-1:0] QNAN    = 32'h7FC00000;
  localparam logic [FP_W-1:0] POS_INF = 32'h7F800000;

  localparam int FLAG_INV = 3;
  localparam int FLAG_DBZ = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } fdiv_state_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  // Denormals (exp == 0) classify as zero: the datapath flushes them.
  function automatic fp_class_t classify(input fp32_t x);
    fp_class_t c;
    c.is_zero = (x.exp == '0);
    c.is_inf  = (x.exp == '1) && (x.frac == '0);
    c.is_nan  = (x.exp == '1) && (x.frac != '0);
    return c;
  endfunction

endpackage

// File: rtl/fp_div_mant.sv
// Restoring radix-2 mantissa divider: one quotient bit per cycle, MSB first.
module fp_div_mant
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [FRAC_W:0]   i_dividend,
  input  logic [FRAC_W:0]   i_divisor,
  output logic [MANT_W-1:0] o_quot,
  output logic              o_done
);

  localparam int              CNT_W = $clog2(MANT_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MANT_W - 1);

  logic [MANT_W-1:0] r_rem;
  logic [FRAC_W:0]   r_div;
  logic [MANT_W-1:0] r_quot;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  logic              w_ge;
  logic [MANT_W-1:0] w_rem_nxt;

  // The remainder after a step is below d < 2^24, so the shift never loses a bit.
  assign w_ge      = r_rem >= {1'b0, r_div};
  assign w_rem_nxt = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= {1'b0, i_dividend};
      r_div  <= i_divisor;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= {w_rem_nxt[MANT_W-2:0], 1'b0};
      r_quot <= {r_quot[MANT_W-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  assign o_quot = r_quot;
  assign o_done = r_busy && (r_cnt == LAST);

endmodule

// File: rtl/fp_div.sv
// Iterative binary32 divider: handshake, special cases, exponent and packing.
//   state | meaning
//   IDLE  | ready for operands
//   DIV   | mantissa divider iterating
//   DONE  | result held until consumer accepts
module fp_div
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] q,
  output logic [3:0]      flags
);

  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] EXP_BIAS = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);

  fdiv_state_t r_state, w_state_nxt;

  logic                  r_sign;
  logic signed [EW2-1:0] r_exp;
  logic                  r_special;
  logic [FP_W-1:0]       r_spec_q;
  logic [3:0]            r_spec_fl;

  fp32_t     w_a, w_b;
  fp_class_t w_ca, w_cb;
  logic      w_sign;
  logic      w_accept;
  logic      w_start;

  logic            w_spec_hit;
  logic [FP_W-1:0] w_spec_q;
  logic [3:0]      w_spec_fl;

  logic [MANT_W-1:0]     w_quot;
  logic                  w_mant_done;
  logic signed [EW2-1:0] w_e;
  logic [FRAC_W-1:0]     w_frac;
  logic [FP_W-1:0]       w_norm_q;
  logic [3:0]            w_norm_fl;

  assign w_a      = a;
  assign w_b      = b;
  assign w_ca     = classify(w_a);
  assign w_cb     = classify(w_b);
  assign w_sign   = w_a.sign ^ w_b.sign;
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_start  = w_accept && !w_spec_hit;

  // Ordered by priority: NaN, indeterminate forms, inf/x, x/0, zero results.
  always_comb begin
    w_spec_hit = 1'b1;
    w_spec_q   = '0;
    w_spec_fl  = '0;
    if (w_ca.is_nan || w_cb.is_nan) begin
      w_spec_q            = QNAN;
      w_spec_fl[FLAG_INV] = 1'b1;
    end else if ((w_ca.is_zero && w_cb.is_zero) || (w_ca.is_inf && w_cb.is_inf)) begin
      w_spec_q            = QNAN;
      w_spec_fl[FLAG_INV] = 1'b1;
    end else if (w_ca.is_inf) begin
      w_spec_q = {w_sign, POS_INF[FP_W-2:0]};
    end else if (w_cb.is_zero) begin
      w_spec_q            = {w_sign, POS_INF[FP_W-2:0]};
      w_spec_fl[FLAG_DBZ] = 1'b1;
    end else if (w_ca.is_zero || w_cb.is_inf) begin
      w_spec_q = {w_sign, {(FP_W-1){1'b0}}};
    end else begin
      w_spec_hit = 1'b0;
    end
  end

  fp_div_mant u_mant (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_dividend ({1'b1, w_a.frac}),
    .i_divisor  ({1'b1, w_b.frac}),
    .o_quot     (w_quot),
    .o_done     (w_mant_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_special <= 1'b0;
      r_spec_q  <= '0;
      r_spec_fl <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sign    <= w_sign;
        r_exp     <= $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp}) + EXP_BIAS;
        r_special <= w_spec_hit;
        r_spec_q  <= w_spec_q;
        r_spec_fl <= w_spec_fl;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_spec_hit ? DONE : DIV;
      DIV:     if (w_mant_done) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Quotient lies in (0.5, 2): Q[24] selects whether to renormalise by one.
  always_comb begin
    w_e       = w_quot[MANT_W-1] ? r_exp : (r_exp - EXP_ONE);
    w_frac    = w_quot[MANT_W-1] ? w_quot[FRAC_W:1] : w_quot[FRAC_W-1:0];
    w_norm_q  = {r_sign, w_e[EXP_W-1:0], w_frac};
    w_norm_fl = '0;
    if (w_e >= EXP_MAX) begin
      w_norm_q            = {r_sign, POS_INF[FP_W-2:0]};
      w_norm_fl[FLAG_OVF] = 1'b1;
    end else if (w_e <= EXP_ZERO) begin
      w_norm_q            = {r_sign, {(FP_W-1){1'b0}}};
      w_norm_fl[FLAG_UNF] = 1'b1;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign q         = out_valid ? (r_special ? r_spec_q  : w_norm_q)  : '0;
  assign flags     = out_valid ? (r_special ? r_spec_fl : w_norm_fl) : '0;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: directed corner cases plus randomized operands.
module tb_fp_div;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q;
  logic [3:0]  flags;

  fp_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rnd_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  fl;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer quotient of the significands, truncated.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rq, output logic [3:0] rf,
                                  output int lat);
    int     ea, eb, e;
    logic   s;
    bit     xn, xi, xz, yn, yi, yz;
    longint ma, mb, qi, mant;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xn = (ea == 255) && (x[22:0] != 0);
    xi = (ea == 255) && (x[22:0] == 0);
    xz = (ea == 0);
    yn = (eb == 255) && (y[22:0] != 0);
    yi = (eb == 255) && (y[22:0] == 0);
    yz = (eb == 0);
    rf  = 4'b0000;
    lat = 1;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      rq = 32'h7FC00000;
      rf = 4'b1000;
    end else if (xi) begin
      rq = {s, 8'hFF, 23'h0};
    end else if (yz) begin
      rq = {s, 8'hFF, 23'h0};
      rf = 4'b0100;
    end else if (xz || yi) begin
      rq = {s, 31'h0};
    end else begin
      lat = 26;
      ma = (64'd1 << 23) + longint'(x[22:0]);
      mb = (64'd1 << 23) + longint'(y[22:0]);
      qi = (ma << 24) / mb;
      e  = ea - eb + 127;
      if (qi >= (64'd1 << 24)) begin
        mant = (qi >> 1) % (64'd1 << 23);
      end else begin
        mant = qi % (64'd1 << 23);
        e    = e - 1;
      end
      if (e >= 255) begin
        rq = {s, 8'hFF, 23'h0};
        rf = 4'b0010;
      end else if (e <= 0) begin
        rq = {s, 31'h0};
        rf = 4'b0001;
      end else begin
        rq = {s, e[7:0], mant[22:0]};
      end
    end
  endfunction

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_op);
    exp_t e;
    int   guard;
    ref_div(ta, tb_op, e.q, e.fl, e.lat);
    guard = 0;
    @(negedge clk);
    a = ta;
    b = tb_op;
    in_valid = 1'b1;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] gen_op();
    int          k;
    logic        s;
    logic [22:0] f;
    logic [7:0]  ex;
    k  = $urandom_range(0, 15);
    s  = 1'($urandom_range(0, 1));
    f  = 23'($urandom());
    ex = 8'($urandom_range(100, 154));
    case (k)
      0:       return {s, 8'h00, 23'h0};
      1:       return {s, 8'h00, f | 23'h1};
      2:       return {s, 8'hFF, 23'h0};
      3:       return {s, 8'hFF, f | 23'h1};
      4, 5:    return {s, 8'($urandom_range(1, 254)), f};
      default: return {s, ex, f};
    endcase
  endfunction

  // Monitor: latency on first out_valid, stability under backpressure, result on transfer.
  bit          seen = 1'b0;
  bit          held = 1'b0;
  logic [31:0] hq;
  logic [3:0]  hf;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_q", q, hq);
        check("hold_flags", {28'b0, flags}, {28'b0, hf});
        check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid q=%h required=no output", q);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
          end
          if (out_ready) begin
            check("q", q, sb[0].q);
            check("flags", {28'b0, flags}, {28'b0, sb[0].fl});
            void'(sb.pop_front());
            seen = 1'b0;
            held = 1'b0;
          end else begin
            held = 1'b1;
            hq   = q;
            hf   = flags;
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time=%0t required=finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_q", q, 32'h0);
    check("rst_flags", {28'b0, flags}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    issue(32'h40C00000, 32'h40000000);
    issue(32'h3F800000, 32'h40400000);
    issue(32'hBF800000, 32'h00000000);
    issue(32'h00000000, 32'h00000000);
    issue(32'h7F000000, 32'h3E800000);
    issue(32'h00800000, 32'h40000000);
    issue(32'h7F800000, 32'h7F800000);
    issue(32'hFF800000, 32'h3F800000);
    issue(32'h80000000, 32'h7F800000);
    issue(32'h7FC00001, 32'h00000000);
    issue(32'h00000123, 32'h40000000);
    drain();

    // Backpressure: hold the result 10 cycles while another operation waits.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    fork
      issue(32'h3F800000, 32'h40400000);
      begin
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
        check("bp_out_valid_after", {31'b0, out_valid}, 32'd0);
      end
    join
    drain();

    // Reset in the middle of an iteration aborts the operation.
    issue(32'h40C00000, 32'h40000000);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_q", q, 32'h0);
    issue(32'h40C00000, 32'h40000000);
    drain();

    rnd_bp = 1'b1;
    for (int i = 0; i < 120; i++) begin
      issue(gen_op(), gen_op());
    end
    drain();
    rnd_bp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
